// File: rtl/neuron_weight_sequencer.sv
// rtl/neuron_weight_sequencer.sv - pairs streamed input samples with sequential weight reads for one neuron pass
// Weight data returns one cycle after ren, so the accepted sample is registered to meet it.
module neuron_weight_sequencer #(
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int numWeight    = 784
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  myinputValid,
  input  logic [dataWidth-1:0]  myinput,
  output logic                  myinputReady,
  output logic                  ren,
  output logic [addressWidth:0] raddr,
  input  logic [dataWidth-1:0]  wout,
  output logic                  mul_valid,
  output logic [dataWidth-1:0]  mul_in,
  output logic [dataWidth-1:0]  mul_w,
  output logic                  mul_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [addressWidth:0] LastIdx = (addressWidth+1)'(numWeight - 1);

  state_e                  state_q, state_d;
  logic [addressWidth:0]   count_q, count_d;
  logic [dataWidth-1:0]    mul_in_q, mul_in_d;
  logic                    mul_valid_q, mul_valid_d;
  logic                    mul_last_q, mul_last_d;
  logic                    accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mul_in_q    <= '0;
      mul_valid_q <= 1'b0;
      mul_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mul_in_q    <= mul_in_d;
      mul_valid_q <= mul_valid_d;
      mul_last_q  <= mul_last_d;
    end
  end

  // Combinational outputs are gated by rst so a reset cycle never issues a read.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    mul_in_d     = mul_in_q;
    mul_valid_d  = 1'b0;
    mul_last_d   = 1'b0;
    myinputReady = 1'b0;
    ren          = 1'b0;
    raddr        = '0;
    busy         = 1'b0;
    done         = 1'b0;
    accept       = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            count_d = '0;
          end
        end
        RUN: begin
          busy         = 1'b1;
          myinputReady = 1'b1;
          accept       = myinputValid;
          if (accept) begin
            ren         = 1'b1;
            raddr       = count_q;
            mul_in_d    = myinput;
            mul_valid_d = 1'b1;
            if (count_q == LastIdx) begin
              mul_last_d = 1'b1;
              state_d    = DRAIN;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          busy    = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mul_valid = mul_valid_q;
  assign mul_in    = mul_in_q;
  assign mul_last  = mul_last_q;
  assign mul_w     = wout;

endmodule
